window_convolver: RTL and testbench
===================================

// Module: window_convolver
// PURPOSE
//   Consumes the window stream from window_fetcher; applies a runtime-loadable WINDOW_HEIGHT x WINDOW_WIDTH integer kernel.
//   Produces one filtered pixel per valid window, with that window's centre col/row attached.
//   Fully pipelined, one window per clock, no backpressure (the upstream stage has none).
//   Kernel updates are double-buffered and take effect only at a frame boundary, so a frame never mixes kernels.
// PARAMETERS
//   DATA_WIDTH     8   unsigned pixel width of window elements
//   IMAGE_WIDTH    5   image columns; col width CW = $clog2(IMAGE_WIDTH)
//   IMAGE_HEIGHT   5   image rows; row width RW = $clog2(IMAGE_HEIGHT)
//   WINDOW_WIDTH   3   kernel columns
//   WINDOW_HEIGHT  3   kernel rows; N = WINDOW_WIDTH*WINDOW_HEIGHT
//   COEF_WIDTH     8   signed two's-complement coefficient width
//   SHIFT          0   right shift applied to the accumulated sum
//   OUT_WIDTH      8   unsigned output pixel width
// PORTS
//   clk_i          in   1                     clock, rising edge
//   rst_i          in   1                     synchronous reset, active-low
//   window_i       in   [WH][WW][DATA_WIDTH]  window, element [r][c], r=0 is top row, c=0 is left column
//   col_i          in   CW                    window centre column
//   row_i          in   RW                    window centre row
//   valid_i        in   1                     window valid
//   coef_i         in   COEF_WIDTH            coefficient, row-major order (index = r*WW+c)
//   coef_valid_i   in   1                     coefficient strobe
//   coef_ready_o   out  1                     shadow bank accepting coefficients
//   kernel_pending_o out 1                    full shadow kernel loaded, awaiting commit
//   pixel_o        out  OUT_WIDTH             filtered pixel
//   col_o          out  CW                    col_i delayed by LATENCY
//   row_o          out  RW                    row_i delayed by LATENCY
//   valid_o        out  1                     valid_i delayed by LATENCY
// BEHAVIOUR
//   Reset (rst_i==0 at posedge):
//     - pixel_o, col_o, row_o, valid_o, kernel_pending_o <= 0; coef_ready_o <= 1.
//     - All pipeline valid bits cleared; in-flight windows are discarded, never emitted.
//     - Active kernel <= identity (centre [(WH-1)/2][(WW-1)/2] = 2**SHIFT, all others 0).
//     - Load index <= 0; frame-seen flag <= 0.
//   Latency: LATENCY = 2 + $clog2(N) cycles (6 for 3x3).
//     - Stage 1: N signed products, each {1'b0,data} * coef.
//     - Stages 2..$clog2(N)+1: registered pairwise adder tree; an odd leftover operand passes through.
//     - Final stage: round, shift, clamp.
//   Accumulator width: AW = DATA_WIDTH + 1 + COEF_WIDTH + $clog2(N), signed; no overflow possible.
//   Round/shift: if SHIFT>0, add 2**(SHIFT-1) before the arithmetic >>> SHIFT (round half up).
//   Coefficient load:
//     - A coefficient is accepted when coef_valid_i && coef_ready_o; it is written to shadow[index] and index increments.
//     - Accepting index N-1: index <= 0, kernel_pending_o <= 1, coef_ready_o <= 0.
//     - coef_valid_i while coef_ready_o==0 is dropped.
//   Frame boundary: valid_i && (frame-seen==0 || row_i < row of the previous valid window).
//   Commit: at a frame boundary with kernel_pending_o==1:
//     - active <= shadow; kernel_pending_o <= 0; coef_ready_o <= 1.
//     - The boundary window itself is multiplied with the shadow (new) kernel.
//   Accepting the last coefficient in the same cycle as a boundary: no commit that cycle; the commit happens at the next boundary.
//   Coordinates: col_o/row_o/valid_o are a pure delay line; there is no reordering or dropping apart from reset.
// CONFIGURATION
//   `WINDOW_CONVOLVER_SATURATE_EN defined: shifted sum clamped to [0, 2**OUT_WIDTH-1].
//   Not defined: pixel_o = shifted_sum[OUT_WIDTH-1:0] (wrap). Latency is identical in both builds.
// STRUCTURE
//   window_convolver_pkg holds:
//     - functions: acc_width(), tree_depth(), latency()
//     - typedefs: coef_t, acc_t
//     - identity-kernel constant builder
//   Sub-module window_convolver_adder_tree: parameterised registered reduction tree.
//     - Ports: operand array plus a valid/coordinate sideband carried level by level.
//   The top level holds the kernel banks, load FSM (LOADING / PENDING), frame detection, multiply stage and output stage.
// TESTING (3x3, DW=8, CW=8, OUT=8, SHIFT=0 unless noted; reuse the WindowFetcher* bench classes with a convolver golden model)
//   1. After reset, no load; window all 37, col=2, row=3 -> 6 cycles later pixel_o=37, col_o=2, row_o=3, valid_o=1.
//   2. Load nine coefficients of 1, then a new frame (row=0 after row=4); window all 10 -> 90; pending 1 -> 0 on commit.
//   3. Box kernel, window all 255:
//        SATURATE_EN defined -> 255; not defined -> 2295 & 255 = 247.
//      Centre coefficient -1, window 5: defined -> 0; not defined -> 251.
//   4. SHIFT=3; kernel all 1; window 3 (sum 27) -> (27+4)>>3 = 3.
//      Load kernel mid-frame -> old kernel holds until the next row wrap; a 10th coefficient while pending is ignored.
//   5. Back-to-back 25 windows of a 5x5 frame -> 25 outputs, consecutive, in order, each matching the golden model.
//   6. rst_i low for 1 cycle with 4 windows in flight -> valid_o=0 from the next cycle; none of the 4 emerge; kernel back to identity.

Source files
------------

// File: rtl/window_convolver_pkg.sv
// window_convolver_pkg: sizing helpers, shared types and the identity-kernel builder
package window_convolver_pkg;
   function automatic int tree_depth(input int n);
      return $clog2(n);
   endfunction
   function automatic int acc_width(input int dw, input int cw, input int n);
      return dw + 1 + cw + tree_depth(n);
   endfunction
   function automatic int latency(input int n);
      return 2 + tree_depth(n);
   endfunction
   function automatic int identity_coef(input int idx, input int wh, input int ww, input int shift);
      return (idx == ((wh - 1) / 2) * ww + (ww - 1) / 2) ? (1 << shift) : 0;
   endfunction
   localparam int DEF_COEF_WIDTH = 8;
   localparam int DEF_ACC_WIDTH = acc_width(8, DEF_COEF_WIDTH, 9);
   typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;
   typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;
   typedef enum logic {LOADING, PENDING} load_state_t;
endpackage

// File: rtl/window_convolver_adder_tree.sv
// window_convolver_adder_tree: registered pairwise reduction with a valid/sideband pipe alongside
module window_convolver_adder_tree
   import window_convolver_pkg::*;
#(
   parameter int N = 9,
   parameter int AW = 21,
   parameter int SW = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic signed [AW-1:0] op_i [N],
   input  logic                 valid_i,
   input  logic [SW-1:0]        sb_i,
   output logic signed [AW-1:0] sum_o,
   output logic                 valid_o,
   output logic [SW-1:0]        sb_o
);
   localparam int D = tree_depth(N);
   localparam int P = 1 << D;
   logic signed [AW-1:0] lvl [D+1][P];
   logic [D:0] vld;
   logic [SW-1:0] sb [D+1];
   // zero padding up to a power of two lets an odd leftover pass through unchanged
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N; i++) lvl[0][i] <= op_i[i];
      for (int i = N; i < P; i++) lvl[0][i] <= '0;
      for (int l = 1; l <= D; l++)
         for (int i = 0; i < (P >> l); i++)
            lvl[l][i] <= lvl[l-1][2*i] + lvl[l-1][2*i+1];
   end
   always_ff @(posedge clk_i) begin
      sb[0] <= sb_i;
      for (int l = 1; l <= D; l++) sb[l] <= sb[l-1];
   end
   always_ff @(posedge clk_i) vld <= !rst_i ? '0 : {vld[D-1:0], valid_i};
   assign sum_o = lvl[D][0];
   assign valid_o = vld[D];
   assign sb_o = sb[D];
endmodule

// File: rtl/window_convolver.sv
// window_convolver: double-buffered kernel convolution of a window stream; WINDOW_CONVOLVER_SATURATE_EN clamps instead of wraps
module window_convolver
   import window_convolver_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMAGE_WIDTH = 5,
   parameter int IMAGE_HEIGHT = 5,
   parameter int WINDOW_WIDTH = 3,
   parameter int WINDOW_HEIGHT = 3,
   parameter int COEF_WIDTH = 8,
   parameter int SHIFT = 0,
   parameter int OUT_WIDTH = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [DATA_WIDTH-1:0]           window_i [WINDOW_HEIGHT][WINDOW_WIDTH],
   input  logic [$clog2(IMAGE_WIDTH)-1:0]  col_i,
   input  logic [$clog2(IMAGE_HEIGHT)-1:0] row_i,
   input  logic                            valid_i,
   input  logic [COEF_WIDTH-1:0]           coef_i,
   input  logic                            coef_valid_i,
   output logic                            coef_ready_o,
   output logic                            kernel_pending_o,
   output logic [OUT_WIDTH-1:0]            pixel_o,
   output logic [$clog2(IMAGE_WIDTH)-1:0]  col_o,
   output logic [$clog2(IMAGE_HEIGHT)-1:0] row_o,
   output logic                            valid_o
);
   localparam int N = WINDOW_WIDTH * WINDOW_HEIGHT;
   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH, N);
   localparam int IW = $clog2(N);
   localparam logic signed [AW-1:0] RND = AW'((1 << SHIFT) >> 1);
   load_state_t st, st_nx;
   logic [IW-1:0] idx;
   logic signed [COEF_WIDTH-1:0] active [N];
   logic signed [COEF_WIDTH-1:0] shadow [N];
   logic seen;
   logic [RW-1:0] prev_row;
   logic accept, boundary, commit;
   logic signed [AW-1:0] prod [N];
   logic signed [AW-1:0] sum;
   logic tree_valid;
   logic [CW+RW-1:0] tree_sb;
   logic [OUT_WIDTH-1:0] pix_nx;
   assign coef_ready_o = st == LOADING;
   assign kernel_pending_o = st == PENDING;
   assign accept = coef_valid_i && coef_ready_o;
   assign boundary = valid_i && (!seen || row_i < prev_row);
   assign commit = boundary && kernel_pending_o;
   always_comb st_nx = (st == LOADING && accept && idx == IW'(N - 1)) ? PENDING :
                       (st == PENDING && commit) ? LOADING : st;
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         st <= LOADING;
         idx <= '0;
         seen <= 1'b0;
         prev_row <= '0;
         for (int i = 0; i < N; i++)
            active[i] <= COEF_WIDTH'(identity_coef(i, WINDOW_HEIGHT, WINDOW_WIDTH, SHIFT));
      end else begin
         st <= st_nx;
         if (accept) idx <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
         if (valid_i) begin
            seen <= 1'b1;
            prev_row <= row_i;
         end
         if (commit) active <= shadow;
      end
   end
   always_ff @(posedge clk_i) if (accept) shadow[idx] <= coef_i;
   // the boundary window that commits a kernel is already filtered with it
   always_comb
      for (int r = 0; r < WINDOW_HEIGHT; r++)
         for (int c = 0; c < WINDOW_WIDTH; c++)
            prod[r*WINDOW_WIDTH+c] = $signed(AW'({1'b0, window_i[r][c]})) *
               $signed(AW'(commit ? shadow[r*WINDOW_WIDTH+c] : active[r*WINDOW_WIDTH+c]));
   window_convolver_adder_tree #(.N(N), .AW(AW), .SW(CW + RW)) u_tree (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .op_i(prod),
      .valid_i(valid_i),
      .sb_i({col_i, row_i}),
      .sum_o(sum),
      .valid_o(tree_valid),
      .sb_o(tree_sb)
   );
`ifdef WINDOW_CONVOLVER_SATURATE_EN
   localparam logic signed [AW-1:0] PMAX = AW'((1 << OUT_WIDTH) - 1);
   logic signed [AW-1:0] shifted;
   assign shifted = (sum + RND) >>> SHIFT;
   assign pix_nx = shifted < 0 ? '0 : shifted > PMAX ? '1 : shifted[OUT_WIDTH-1:0];
`else
   assign pix_nx = OUT_WIDTH'((sum + RND) >>> SHIFT);
`endif
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pixel_o <= '0;
         col_o <= '0;
         row_o <= '0;
         valid_o <= 1'b0;
      end else begin
         pixel_o <= pix_nx;
         {col_o, row_o} <= tree_sb;
         valid_o <= tree_valid;
      end
   end
endmodule

// File: tb/tb_window_convolver.sv
// tb_window_convolver: two instances (SHIFT 0 and 3) checked every cycle against a plain-arithmetic convolution model
module tb_window_convolver;
   localparam int N = 9;
   localparam int LAT = 6;
`ifdef WINDOW_CONVOLVER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef struct {
      bit v;
      int pix0;
      int pix1;
      int col;
      int row;
   } ent_t;
   logic clk, rst, valid, coef_valid;
   logic [7:0] win [3][3];
   logic [2:0] col, row;
   logic [7:0] coef;
   logic ready0, pend0, valid0, ready3, pend3, valid3;
   logic [7:0] pixel0, pixel3;
   logic [2:0] col0, row0, col3, row3;
   int total = 0, bad = 0, out_cnt = 0;
   int act [2][N];
   int shd [N];
   int lidx, prow;
   bit pend, seen;
   ent_t hist [$];

   window_convolver dut0 (
      .clk_i(clk), .rst_i(rst), .window_i(win), .col_i(col), .row_i(row), .valid_i(valid),
      .coef_i(coef), .coef_valid_i(coef_valid), .coef_ready_o(ready0), .kernel_pending_o(pend0),
      .pixel_o(pixel0), .col_o(col0), .row_o(row0), .valid_o(valid0)
   );
   window_convolver #(.SHIFT(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .window_i(win), .col_i(col), .row_i(row), .valid_i(valid),
      .coef_i(coef), .coef_valid_i(coef_valid), .coef_ready_o(ready3), .kernel_pending_o(pend3),
      .pixel_o(pixel3), .col_o(col3), .row_o(row3), .valid_o(valid3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endfunction

   function automatic int fin(input int s, input int sh);
      int t;
      t = (s + ((1 << sh) >> 1)) >>> sh;
      return SAT ? (t < 0 ? 0 : t > 255 ? 255 : t) : (t & 255);
   endfunction

   // reference: one entry per sampled cycle, the output shows the entry LAT-1 edges older
   always @(posedge clk) begin
      ent_t e;
      int s;
      bit bnd, cm;
      if (!rst) begin
         for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) act[j][i] = (i == 4) ? (j == 1 ? 8 : 1) : 0;
         lidx = 0;
         pend = 0;
         seen = 0;
         prow = 0;
         hist.delete();
         e = '{0, 0, 0, 0, 0};
         repeat (LAT) hist.push_back(e);
      end else begin
         bnd = valid && (!seen || int'(row) < prow);
         cm = bnd && pend;
         e.v = valid;
         e.col = int'(col);
         e.row = int'(row);
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += int'(win[i/3][i%3]) * (cm ? shd[i] : act[j][i]);
            if (j == 0) e.pix0 = fin(s, 0);
            else e.pix1 = fin(s, 3);
         end
         if (cm) begin
            for (int j = 0; j < 2; j++)
               for (int i = 0; i < N; i++) act[j][i] = shd[i];
            pend = 0;
         end else if (!pend && coef_valid) begin
            shd[lidx] = int'($signed(coef));
            lidx++;
            if (lidx == N) begin
               lidx = 0;
               pend = 1;
            end
         end
         if (valid) begin
            seen = 1;
            prow = int'(row);
         end
         hist.push_back(e);
         if (hist.size() > LAT) void'(hist.pop_front());
      end
   end

   always @(negedge clk) begin
      if (hist.size() == LAT) begin
         chk("valid_o", valid0, hist[0].v);
         chk("valid_o_s3", valid3, hist[0].v);
         if (hist[0].v) begin
            chk("pixel_o", pixel0, hist[0].pix0);
            chk("pixel_o_s3", pixel3, hist[0].pix1);
            chk("col_o", col0, hist[0].col);
            chk("row_o", row0, hist[0].row);
            chk("col_o_s3", col3, hist[0].col);
            chk("row_o_s3", row3, hist[0].row);
         end
         chk("coef_ready_o", ready0, !pend);
         chk("kernel_pending_o", pend0, pend);
         chk("coef_ready_o_s3", ready3, !pend);
         chk("kernel_pending_o_s3", pend3, pend);
         if (valid0) out_cnt++;
      end
   end

   task automatic set_win(input int v);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) win[r][c] = 8'(v);
   endtask

   task automatic rand_win();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) win[r][c] = 8'($urandom);
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      coef_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic win_all(input int v, input int c, input int r);
      set_win(v);
      col = 3'(c);
      row = 3'(r);
      valid = 1'b1;
      coef_valid = 1'b0;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic load_const(input int v, input int centre);
      for (int i = 0; i < N; i++) begin
         coef_valid = 1'b1;
         coef = 8'(i == 4 ? centre : v);
         @(negedge clk);
      end
      coef_valid = 1'b0;
   endtask

   initial begin
      int n0, rr, cc;
      rst = 1'b0;
      valid = 1'b0;
      coef_valid = 1'b0;
      coef = '0;
      col = '0;
      row = '0;
      set_win(0);
      repeat (2) @(negedge clk);
      chk("rst_pixel", pixel0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_col", col0, 0);
      chk("rst_row", row0, 0);
      chk("rst_pending", pend0, 0);
      chk("rst_ready", ready0, 1);
      rst = 1'b1;
      win_all(37, 2, 3);
      idle(5);
      chk("identity_pix", pixel0, 37);
      chk("identity_pix_s3", pixel3, 37);
      chk("identity_col", col0, 2);
      chk("identity_row", row0, 3);
      chk("identity_valid", valid0, 1);
      load_const(1, 1);
      chk("pending_set", pend0, 1);
      chk("ready_clr", ready0, 0);
      coef_valid = 1'b1;
      coef = 8'd99;
      @(negedge clk);
      coef_valid = 1'b0;
      win_all(10, 1, 4);
      win_all(10, 2, 0);
      chk("pending_clr", pend0, 0);
      chk("ready_set", ready0, 1);
      idle(5);
      chk("box10", pixel0, 90);
      chk("box10_s3", pixel3, 11);
      win_all(3, 0, 1);
      idle(5);
      chk("box3", pixel0, 27);
      chk("box3_s3", pixel3, 3);
      win_all(255, 1, 1);
      idle(5);
      chk("box255", pixel0, SAT ? 255 : 247);
      chk("box255_s3", pixel3, SAT ? 255 : 31);
      load_const(0, -1);
      win_all(5, 2, 2);
      idle(5);
      chk("old_kernel_holds", pixel0, 45);
      chk("old_kernel_holds_s3", pixel3, 6);
      win_all(5, 2, 0);
      idle(5);
      chk("neg_centre", pixel0, SAT ? 0 : 251);
      chk("neg_centre_s3", pixel3, SAT ? 0 : 255);
      win_all(7, 0, 3);
      for (int i = 0; i < N; i++) begin
         coef_valid = 1'b1;
         coef = 8'($urandom);
         @(negedge clk);
      end
      coef_valid = 1'b0;
      n0 = out_cnt;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            rand_win();
            col = 3'(c);
            row = 3'(r);
            valid = 1'b1;
            @(negedge clk);
         end
      idle(6);
      chk("frame_count", out_cnt - n0, 25);
      rr = 0;
      cc = 0;
      repeat (400) begin
         valid = ($urandom % 3) != 0;
         rand_win();
         col = 3'(cc);
         row = 3'(rr);
         coef_valid = ($urandom % 4) == 0;
         coef = 8'($urandom);
         @(negedge clk);
         if (valid) begin
            cc = (cc == 4) ? 0 : cc + 1;
            if (cc == 0) rr = (rr == 4) ? 0 : rr + 1;
         end
      end
      idle(1);
      repeat (N) begin
         coef_valid = 1'b1;
         coef = 8'($urandom);
         @(negedge clk);
      end
      coef_valid = 1'b0;
      chk("pending_before_rst", pend0, 1);
      for (int i = 0; i < 4; i++) begin
         rand_win();
         col = 3'(i);
         row = 3'd1;
         valid = 1'b1;
         @(negedge clk);
      end
      valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_mid_valid", valid0, 0);
      chk("rst_mid_pending", pend0, 0);
      chk("rst_mid_ready", ready0, 1);
      repeat (LAT) begin
         @(negedge clk);
         chk("flushed_valid", valid0, 0);
      end
      win_all(37, 1, 1);
      idle(5);
      chk("rst_identity", pixel0, 37);
      chk("rst_identity_s3", pixel3, 37);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
